// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_fetch_pkg;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

    // Instruction addresses are word aligned; stray low bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_redirect_latch.sv
// Holds a redirect target that arrived while the delay-slot fetch was still in flight.
module if_redirect_latch
    import if_fetch_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        set,
    input  logic [31:0] set_target,
    input  logic        consume,
    input  logic        clear,
    output logic        valid,
    output logic [31:0] target
);

    // NOTE: state is only ever written with <= so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid  <= 1'b0;
            target <= '0;
        end else if (clear) begin
            valid  <= 1'b0;
        end else if (set) begin
            valid  <= 1'b1;
            target <= align_word(set_target);
        end else if (consume) begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, runs the IMEM request/ready handshake and applies
// branch, jump and exception redirects toward the IF/ID register.
module if_fetch_unit
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
)
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        ID_Stall,
    input  logic [1:0]  ID_PCSrc,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] JumpTarget,
    input  logic        ID_IsBranchOrJump,
    input  logic        ID_CancelBDS,
    input  logic        Exc_Flush,
    input  logic [31:0] ExcTarget,
    output logic        IMEM_Req,
    output logic [31:0] IMEM_Addr,
    input  logic        IMEM_Ready,
    input  logic [31:0] IMEM_RData,
    output logic [31:0] IF_Instruction,
    output logic [31:0] PCAdd4,
    output logic [31:0] PCOut,
    output logic        IF_IsBDS,
    output logic        IF_Stall,
    output logic        IF_Flush
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  drain_addr, drain_addr_nxt;
    logic [31:0]  hold_buf, hold_buf_nxt;
    logic         bds, bds_nxt;

    logic         pend_valid;
    logic [31:0]  pend_target;
    logic         pend_set, pend_consume, pend_clear;

    logic [31:0]  seq_pc;
    logic [31:0]  advance_pc;
    logic         redirect_req;

    assign seq_pc       = pc + 32'd4;
    assign redirect_req = (ID_PCSrc == PCSRC_BRANCH) || (ID_PCSrc == PCSRC_JUMP);

    if_redirect_latch u_redirect (
        .CLK        (CLK),
        .RST        (RST),
        .set        (pend_set),
        .set_target (ID_PCSrc == PCSRC_JUMP ? JumpTarget : BranchTarget),
        .consume    (pend_consume),
        .clear      (pend_clear),
        .valid      (pend_valid),
        .target     (pend_target)
    );

    // A redirect latched during the delay-slot fetch outranks whatever ID shows now.
    always_comb begin
        advance_pc = seq_pc;
        if (pend_valid)
            advance_pc = pend_target;
        else if (ID_PCSrc == PCSRC_BRANCH)
            advance_pc = align_word(BranchTarget);
        else if (ID_PCSrc == PCSRC_JUMP)
            advance_pc = align_word(JumpTarget);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= WAIT;
            pc         <= align_word(RESET_VECTOR);
            drain_addr <= '0;
            hold_buf   <= '0;
            bds        <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            drain_addr <= drain_addr_nxt;
            hold_buf   <= hold_buf_nxt;
            bds        <= bds_nxt;
        end
    end

    // NOTE: every output of this block is defaulted up front, so no path infers a latch.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        drain_addr_nxt = drain_addr;
        hold_buf_nxt   = hold_buf;
        bds_nxt        = bds;
        pend_set       = 1'b0;
        pend_consume   = 1'b0;
        pend_clear     = 1'b0;
        IMEM_Req       = 1'b0;
        IMEM_Addr      = pc;
        IF_Instruction = '0;
        IF_Stall       = 1'b1;

        case (state)
            WAIT: begin
                IMEM_Req       = 1'b1;
                IF_Instruction = IMEM_RData;
                IF_Stall       = ~IMEM_Ready;
            end
            HOLD: begin
                IF_Instruction = hold_buf;
                IF_Stall       = 1'b0;
            end
            DRAIN: begin
                IMEM_Req  = 1'b1;
                IMEM_Addr = drain_addr;
            end
            default: ;
        endcase

        if (Exc_Flush) begin
            pc_nxt       = align_word(ExcTarget);
            pend_clear   = 1'b1;
            bds_nxt      = 1'b0;
            hold_buf_nxt = '0;
            case (state)
                WAIT: begin
                    // An unfinished request must still complete before refetching.
                    if (!IMEM_Ready) begin
                        state_nxt      = DRAIN;
                        drain_addr_nxt = pc;
                    end
                end
                HOLD:    state_nxt = WAIT;
                DRAIN:   if (IMEM_Ready) state_nxt = WAIT;
                default: state_nxt = WAIT;
            endcase
        end else begin
            case (state)
                WAIT: begin
                    if (IMEM_Ready) begin
                        if (!ID_Stall) begin
                            pc_nxt       = advance_pc;
                            pend_consume = pend_valid;
                            bds_nxt      = 1'b0;
                        end else begin
                            hold_buf_nxt = IMEM_RData;
                            state_nxt    = HOLD;
                        end
                    end else if (redirect_req && !ID_Stall) begin
                        pend_set = 1'b1;
                    end
                end
                HOLD: begin
                    if (!ID_Stall) begin
                        pc_nxt       = advance_pc;
                        pend_consume = pend_valid;
                        bds_nxt      = 1'b0;
                        state_nxt    = WAIT;
                    end
                end
                DRAIN: begin
                    if (IMEM_Ready)
                        state_nxt = WAIT;
                end
                default: state_nxt = WAIT;
            endcase
            // Marking the following instruction as a delay slot wins over clearing.
            if (ID_IsBranchOrJump && !ID_Stall)
                bds_nxt = 1'b1;
        end

        if (RST) begin
            IMEM_Req       = 1'b0;
            IF_Instruction = '0;
            IF_Stall       = 1'b1;
        end
    end

    assign PCOut    = pc;
    assign PCAdd4   = seq_pc;
    assign IF_IsBDS = bds;
    assign IF_Flush = ~RST & (ID_CancelBDS | Exc_Flush);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: one task per scenario with inline checks.
module tb_if_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ID_Stall;
    logic [1:0]  ID_PCSrc;
    logic [31:0] BranchTarget;
    logic [31:0] JumpTarget;
    logic        ID_IsBranchOrJump;
    logic        ID_CancelBDS;
    logic        Exc_Flush;
    logic [31:0] ExcTarget;
    logic        IMEM_Req;
    logic [31:0] IMEM_Addr;
    logic        IMEM_Ready;
    logic [31:0] IMEM_RData;
    logic [31:0] IF_Instruction;
    logic [31:0] PCAdd4;
    logic [31:0] PCOut;
    logic        IF_IsBDS;
    logic        IF_Stall;
    logic        IF_Flush;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    if_fetch_unit dut (
        .CLK               (CLK),
        .RST               (RST),
        .ID_Stall          (ID_Stall),
        .ID_PCSrc          (ID_PCSrc),
        .BranchTarget      (BranchTarget),
        .JumpTarget        (JumpTarget),
        .ID_IsBranchOrJump (ID_IsBranchOrJump),
        .ID_CancelBDS      (ID_CancelBDS),
        .Exc_Flush         (Exc_Flush),
        .ExcTarget         (ExcTarget),
        .IMEM_Req          (IMEM_Req),
        .IMEM_Addr         (IMEM_Addr),
        .IMEM_Ready        (IMEM_Ready),
        .IMEM_RData        (IMEM_RData),
        .IF_Instruction    (IF_Instruction),
        .PCAdd4            (PCAdd4),
        .PCOut             (PCOut),
        .IF_IsBDS          (IF_IsBDS),
        .IF_Stall          (IF_Stall),
        .IF_Flush          (IF_Flush)
    );

    // Holds reset for two cycles, returns at a falling edge with RST low.
    task automatic do_reset();
        RST = 1'b1;
        ID_Stall = 1'b0;
        ID_PCSrc = 2'b00;
        BranchTarget = '0;
        JumpTarget = '0;
        ID_IsBranchOrJump = 1'b0;
        ID_CancelBDS = 1'b0;
        Exc_Flush = 1'b0;
        ExcTarget = '0;
        IMEM_Ready = 1'b1;
        IMEM_RData = 32'h0000_0000;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        ID_CancelBDS = 1'b1;
        IMEM_RData = 32'hFFFF_FFFF;
        #1;
        tests++; if (IMEM_Req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", IMEM_Req); end
        tests++; if (IF_Stall !== 1'b1) begin fails++; $display("FAIL rst_stall: got %b want 1", IF_Stall); end
        tests++; if (IF_Flush !== 1'b0) begin fails++; $display("FAIL rst_flush: got %b want 0", IF_Flush); end
        tests++; if (IF_IsBDS !== 1'b0) begin fails++; $display("FAIL rst_bds: got %b want 0", IF_IsBDS); end
        tests++; if (IF_Instruction !== 32'h0) begin fails++; $display("FAIL rst_instr: got %h want 00000000", IF_Instruction); end
        tests++; if (PCOut !== 32'hBFC0_0000) begin fails++; $display("FAIL rst_pc: got %h want bfc00000", PCOut); end
        ID_CancelBDS = 1'b0;
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp_addr [3];
        exp_addr[0] = 32'hBFC0_0000;
        exp_addr[1] = 32'hBFC0_0004;
        exp_addr[2] = 32'hBFC0_0008;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            IMEM_RData = 32'h2400_0000 + i;
            #1;
            tests++; if (IMEM_Req !== 1'b1 || IMEM_Addr !== exp_addr[i])
                begin fails++; $display("FAIL zw_addr%0d: got req=%b addr=%h want req=1 addr=%h", i, IMEM_Req, IMEM_Addr, exp_addr[i]); end
            tests++; if (IF_Stall !== 1'b0) begin fails++; $display("FAIL zw_stall%0d: got %b want 0", i, IF_Stall); end
            tests++; if (IF_Instruction !== 32'h2400_0000 + i)
                begin fails++; $display("FAIL zw_instr%0d: got %h want %h", i, IF_Instruction, 32'h2400_0000 + i); end
            tests++; if (PCAdd4 !== exp_addr[i] + 32'd4)
                begin fails++; $display("FAIL zw_pc4_%0d: got %h want %h", i, PCAdd4, exp_addr[i] + 32'd4); end
            @(negedge CLK);
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        @(negedge CLK);
        IMEM_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (IMEM_Addr !== 32'hBFC0_0004 || IF_Stall !== 1'b1 || PCOut !== 32'hBFC0_0004)
                begin fails++; $display("FAIL ws_wait%0d: got addr=%h stall=%b pc=%h want bfc00004/1/bfc00004", i, IMEM_Addr, IF_Stall, PCOut); end
            @(negedge CLK);
        end
        IMEM_Ready = 1'b1;
        #1;
        tests++; if (IMEM_Addr !== 32'hBFC0_0004 || IF_Stall !== 1'b0)
            begin fails++; $display("FAIL ws_deliver: got addr=%h stall=%b want bfc00004/0", IMEM_Addr, IF_Stall); end
        @(negedge CLK);
        #1;
        tests++; if (IMEM_Addr !== 32'hBFC0_0008)
            begin fails++; $display("FAIL ws_next: got %h want bfc00008", IMEM_Addr); end
    endtask

    task automatic test_branch();
        do_reset();
        ID_IsBranchOrJump = 1'b1;
        #1;
        tests++; if (IF_IsBDS !== 1'b0) begin fails++; $display("FAIL br_bds0: got %b want 0", IF_IsBDS); end
        @(negedge CLK);
        ID_IsBranchOrJump = 1'b0;
        ID_PCSrc = 2'b01;
        BranchTarget = 32'h8000_1003;
        #1;
        tests++; if (IMEM_Addr !== 32'hBFC0_0004 || IF_IsBDS !== 1'b1)
            begin fails++; $display("FAIL br_slot: got addr=%h bds=%b want bfc00004/1", IMEM_Addr, IF_IsBDS); end
        @(negedge CLK);
        ID_PCSrc = 2'b00;
        #1;
        tests++; if (IMEM_Addr !== 32'h8000_1000 || IF_IsBDS !== 1'b0)
            begin fails++; $display("FAIL br_target: got addr=%h bds=%b want 80001000/0", IMEM_Addr, IF_IsBDS); end
    endtask

    task automatic test_pending_redirect();
        do_reset();
        @(negedge CLK);
        IMEM_Ready = 1'b0;
        ID_PCSrc = 2'b01;
        ID_IsBranchOrJump = 1'b1;
        BranchTarget = 32'h8000_2000;
        @(negedge CLK);
        ID_PCSrc = 2'b00;
        ID_IsBranchOrJump = 1'b0;
        BranchTarget = 32'h0;
        #1;
        tests++; if (IMEM_Addr !== 32'hBFC0_0004 || IF_Stall !== 1'b1 || IF_IsBDS !== 1'b1)
            begin fails++; $display("FAIL pr_wait: got addr=%h stall=%b bds=%b want bfc00004/1/1", IMEM_Addr, IF_Stall, IF_IsBDS); end
        @(negedge CLK);
        IMEM_Ready = 1'b1;
        #1;
        tests++; if (IMEM_Addr !== 32'hBFC0_0004 || IF_Stall !== 1'b0 || IF_IsBDS !== 1'b1)
            begin fails++; $display("FAIL pr_slot: got addr=%h stall=%b bds=%b want bfc00004/0/1", IMEM_Addr, IF_Stall, IF_IsBDS); end
        @(negedge CLK);
        #1;
        tests++; if (IMEM_Addr !== 32'h8000_2000 || IF_IsBDS !== 1'b0)
            begin fails++; $display("FAIL pr_target: got addr=%h bds=%b want 80002000/0", IMEM_Addr, IF_IsBDS); end
        @(negedge CLK);
        #1;
        tests++; if (IMEM_Addr !== 32'h8000_2004)
            begin fails++; $display("FAIL pr_after: got %h want 80002004", IMEM_Addr); end
    endtask

    task automatic test_exception_drain();
        do_reset();
        @(negedge CLK);
        IMEM_Ready = 1'b0;
        Exc_Flush = 1'b1;
        ExcTarget = 32'h8000_0100;
        #1;
        tests++; if (IF_Flush !== 1'b1 || IF_Stall !== 1'b1)
            begin fails++; $display("FAIL ex_flush: got flush=%b stall=%b want 1/1", IF_Flush, IF_Stall); end
        @(negedge CLK);
        ExcTarget = 32'h8000_0183;
        #1;
        tests++; if (IMEM_Req !== 1'b1 || IMEM_Addr !== 32'hBFC0_0004 || IF_Stall !== 1'b1)
            begin fails++; $display("FAIL ex_drain0: got req=%b addr=%h stall=%b want 1/bfc00004/1", IMEM_Req, IMEM_Addr, IF_Stall); end
        @(negedge CLK);
        Exc_Flush = 1'b0;
        IMEM_Ready = 1'b1;
        IMEM_RData = 32'hDEAD_BEEF;
        #1;
        tests++; if (IMEM_Addr !== 32'hBFC0_0004 || IF_Stall !== 1'b1 || IF_Flush !== 1'b0)
            begin fails++; $display("FAIL ex_drain1: got addr=%h stall=%b flush=%b want bfc00004/1/0", IMEM_Addr, IF_Stall, IF_Flush); end
        @(negedge CLK);
        #1;
        tests++; if (IMEM_Addr !== 32'h8000_0180 || IF_Stall !== 1'b0 || PCOut !== 32'h8000_0180)
            begin fails++; $display("FAIL ex_refetch: got addr=%h stall=%b pc=%h want 80000180/0/80000180", IMEM_Addr, IF_Stall, PCOut); end
    endtask

    task automatic test_hold_and_reset();
        do_reset();
        ID_Stall = 1'b1;
        IMEM_RData = 32'h2402_0001;
        #1;
        tests++; if (IF_Instruction !== 32'h2402_0001 || IF_Stall !== 1'b0)
            begin fails++; $display("FAIL hd_deliver: got instr=%h stall=%b want 24020001/0", IF_Instruction, IF_Stall); end
        @(negedge CLK);
        IMEM_RData = 32'hDEAD_BEEF;
        #1;
        tests++; if (IMEM_Req !== 1'b0 || IF_Instruction !== 32'h2402_0001 || IF_Stall !== 1'b0 || PCOut !== 32'hBFC0_0000)
            begin fails++; $display("FAIL hd_hold: got req=%b instr=%h stall=%b pc=%h want 0/24020001/0/bfc00000", IMEM_Req, IF_Instruction, IF_Stall, PCOut); end
        @(negedge CLK);
        ID_Stall = 1'b0;
        #1;
        tests++; if (IMEM_Req !== 1'b0 || IF_Instruction !== 32'h2402_0001)
            begin fails++; $display("FAIL hd_release: got req=%b instr=%h want 0/24020001", IMEM_Req, IF_Instruction); end
        @(negedge CLK);
        ID_Stall = 1'b1;
        #1;
        tests++; if (IMEM_Req !== 1'b1 || IMEM_Addr !== 32'hBFC0_0004)
            begin fails++; $display("FAIL hd_resume: got req=%b addr=%h want 1/bfc00004", IMEM_Req, IMEM_Addr); end
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        tests++; if (IMEM_Req !== 1'b0 || PCOut !== 32'hBFC0_0000 || IF_Stall !== 1'b1 || IF_Instruction !== 32'h0)
            begin fails++; $display("FAIL hd_async_rst: got req=%b pc=%h stall=%b instr=%h want 0/bfc00000/1/00000000", IMEM_Req, PCOut, IF_Stall, IF_Instruction); end
        @(negedge CLK);
        RST = 1'b0;
        ID_Stall = 1'b0;
        #1;
        tests++; if (IMEM_Req !== 1'b1 || IMEM_Addr !== 32'hBFC0_0000)
            begin fails++; $display("FAIL hd_restart: got req=%b addr=%h want 1/bfc00000", IMEM_Req, IMEM_Addr); end
    endtask

    task automatic test_wrap_and_cancel();
        do_reset();
        ID_PCSrc = 2'b10;
        JumpTarget = 32'hFFFF_FFFE;
        @(negedge CLK);
        ID_PCSrc = 2'b11;
        BranchTarget = 32'h1234_5678;
        JumpTarget = 32'h8765_4320;
        ID_CancelBDS = 1'b1;
        #1;
        tests++; if (IMEM_Addr !== 32'hFFFF_FFFC || PCAdd4 !== 32'h0)
            begin fails++; $display("FAIL wr_top: got addr=%h pc4=%h want fffffffc/00000000", IMEM_Addr, PCAdd4); end
        tests++; if (IF_Flush !== 1'b1) begin fails++; $display("FAIL wr_cancel: got %b want 1", IF_Flush); end
        @(negedge CLK);
        ID_PCSrc = 2'b00;
        ID_CancelBDS = 1'b0;
        #1;
        tests++; if (IMEM_Addr !== 32'h0 || IF_Flush !== 1'b0)
            begin fails++; $display("FAIL wr_zero: got addr=%h flush=%b want 00000000/0", IMEM_Addr, IF_Flush); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        do_reset();
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_branch();
        test_pending_redirect();
        test_exception_drain();
        test_hold_and_reset();
        test_wrap_and_cancel();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
